// File: rtl/lcd_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the LCD bus arbiter slice.
//   lcd_state_t     : write-sequencer FSM states
//   RS_CMD/RS_CHAR  : register-select encodings on lcd_rs
//   LCD_DEFAULT_CYC : default lcd_en high/low durations in clk cycles
// ---------------------------------------------------------------------------
package lcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } lcd_state_t;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_CHAR = 1'b1;

    localparam int LCD_DEFAULT_CYC = 50000;

    localparam int CNT_W = 16;

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// lcd_bus_arbiter_if
// Requester-side handshake plus the LCD pin bundle.
//   req[1:0]       : per-requester write request
//   req_rs[1:0]    : per-requester register select (0 cmd, 1 char)
//   req_data0/1    : per-requester byte
//   ack[1:0]       : one-cycle completion pulse to the granted requester
//   busy           : high from grant through the ack cycle
//   lcd_en/rw/rs   : LCD strobe, read/write (always write), register select
//   lcd_data[7:0]  : LCD data bus
// Modports: master = requesters / LCD observer, slave = the arbiter.
// ---------------------------------------------------------------------------
interface lcd_bus_arbiter_if;

    logic [1:0] req;
    logic [1:0] req_rs;
    logic [7:0] req_data0;
    logic [7:0] req_data1;
    logic [1:0] ack;
    logic       busy;
    logic       lcd_en;
    logic       lcd_rw;
    logic       lcd_rs;
    logic [7:0] lcd_data;

    modport master (
        output req, req_rs, req_data0, req_data1,
        input  ack, busy, lcd_en, lcd_rw, lcd_rs, lcd_data
    );

    modport slave (
        input  req, req_rs, req_data0, req_data1,
        output ack, busy, lcd_en, lcd_rw, lcd_rs, lcd_data
    );

endinterface

// File: rtl/lcd_bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// lcd_rr_arbiter
// Two-way grant selection for the LCD bus arbiter.
//   req[1:0] : live request vector
//   gnt_idx  : index of the requester that wins this cycle (valid when
//              any req bit is set)
// With LCD_ROUND_ROBIN_EN defined, a pointer register alternates priority
// on simultaneous requests and adds ports:
//   clk, rst_n : clock and synchronous active-low reset (pointer -> 0)
//   take       : a grant is being accepted this cycle; advance the pointer
// Without the macro, requester 0 always wins and no state exists.
// ---------------------------------------------------------------------------
module lcd_rr_arbiter (
`ifdef LCD_ROUND_ROBIN_EN
    input  logic       clk,
    input  logic       rst_n,
    input  logic       take,
`endif
    input  logic [1:0] req,
    output logic       gnt_idx
);

`ifdef LCD_ROUND_ROBIN_EN
    // ptr names the requester favoured on a tie.
    logic ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (take) begin
            // Favour whoever did not just win, regardless of contention.
            ptr <= ~gnt_idx;
        end
    end

    always_comb begin
        gnt_idx = 1'b0;
        if (req == 2'b11) begin
            gnt_idx = ptr;
        end else begin
            gnt_idx = req[1];
        end
    end
`else
    always_comb begin
        gnt_idx = req[1] & ~req[0];
    end
`endif

endmodule

// File: rtl/lcd_bus_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_bus_arbiter
// Arbitrates two requesters onto a single HD44780-style LCD write bus and
// sequences each write as SETUP (1 cycle) -> PULSE (EN_HIGH_CYC cycles,
// lcd_en=1) -> HOLD (EN_LOW_CYC cycles, ack in the final cycle) -> IDLE.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset; aborts any write without ack
//   bus    : lcd_bus_arbiter_if.slave (requests, ack/busy, LCD pins)
// Parameters:
//   EN_HIGH_CYC : lcd_en high time per write, 1..65535
//   EN_LOW_CYC  : lcd_en low time after each pulse, 1..65535
// Configuration macro: LCD_ROUND_ROBIN_EN selects round-robin arbitration
// on simultaneous requests; undefined gives fixed priority to requester 0.
// ---------------------------------------------------------------------------
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int EN_HIGH_CYC = LCD_DEFAULT_CYC,
    parameter int EN_LOW_CYC  = LCD_DEFAULT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    lcd_bus_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(EN_LOW_CYC - 1);
    // Count in HOLD one cycle before the last, where ack gets registered.
    localparam logic [CNT_W-1:0] LOW_PRE   =
        (EN_LOW_CYC >= 2) ? CNT_W'(EN_LOW_CYC - 2) : '0;

    lcd_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             owner;
    logic [1:0]       owner_ack;
    logic             gnt_idx;
    logic             en_q;
    logic             rs_q;
    logic [7:0]       data_q;
    logic [1:0]       ack_q;
    logic             busy_q;

    lcd_rr_arbiter u_arb (
`ifdef LCD_ROUND_ROBIN_EN
        .clk     (clk),
        .rst_n   (rst_n),
        .take    ((state == IDLE) && (|bus.req)),
`endif
        .req     (bus.req),
        .gnt_idx (gnt_idx)
    );

    assign owner_ack = owner ? 2'b10 : 2'b01;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            owner  <= 1'b0;
            en_q   <= 1'b0;
            rs_q   <= RS_CMD;
            data_q <= 8'h00;
            ack_q  <= 2'b00;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (|bus.req) begin
                        // Latch the winner's payload; requests are not
                        // looked at again until we are back in IDLE.
                        state  <= SETUP;
                        owner  <= gnt_idx;
                        busy_q <= 1'b1;
                        rs_q   <= bus.req_rs[gnt_idx];
                        data_q <= gnt_idx ? bus.req_data1 : bus.req_data0;
                    end
                end

                SETUP: begin
                    state <= PULSE;
                    cnt   <= '0;
                    en_q  <= 1'b1;
                end

                PULSE: begin
                    if (cnt == HIGH_LAST) begin
                        state <= HOLD;
                        cnt   <= '0;
                        en_q  <= 1'b0;
                        // A one-cycle HOLD is itself the ack cycle.
                        if (EN_LOW_CYC == 1) begin
                            ack_q <= owner_ack;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                HOLD: begin
                    if (cnt == LOW_LAST) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        ack_q  <= 2'b00;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LOW_PRE) begin
                            ack_q <= owner_ack;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.lcd_en   = en_q;
    assign bus.lcd_rw   = 1'b0;
    assign bus.lcd_rs   = rs_q;
    assign bus.lcd_data = data_q;
    assign bus.ack      = ack_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
module tb_lcd_bus_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    lcd_bus_arbiter_if bus ();

    lcd_bus_arbiter #(
        .EN_HIGH_CYC (4),
        .EN_LOW_CYC  (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Observe one full write starting from the negedge just before the
    // granting edge. Cycles 1..8 are SETUP, 4xPULSE, 3xHOLD; cycle 9 is the
    // mandatory IDLE gap. req_after is driven once the ack is seen.
    task automatic check_txn(input logic [7:0] exp_data, input logic exp_rs,
                             input int idx, input logic [1:0] req_after,
                             input string tag);
        logic [1:0] exp_ack;
        logic       exp_en;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            exp_en  = (c >= 2 && c <= 5);
            exp_ack = (c == 8) ? ((idx == 1) ? 2'b10 : 2'b01) : 2'b00;
            checks++;
            if (bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy cyc%0d: got %b want 1", tag, c, bus.busy);
            end
            checks++;
            if (bus.lcd_data !== exp_data) begin
                errors++;
                $display("FAIL %s lcd_data cyc%0d: got %h want %h", tag, c, bus.lcd_data, exp_data);
            end
            checks++;
            if (bus.lcd_rs !== exp_rs) begin
                errors++;
                $display("FAIL %s lcd_rs cyc%0d: got %b want %b", tag, c, bus.lcd_rs, exp_rs);
            end
            checks++;
            if (bus.lcd_en !== exp_en) begin
                errors++;
                $display("FAIL %s lcd_en cyc%0d: got %b want %b", tag, c, bus.lcd_en, exp_en);
            end
            checks++;
            if (bus.ack !== exp_ack) begin
                errors++;
                $display("FAIL %s ack cyc%0d: got %b want %b", tag, c, bus.ack, exp_ack);
            end
            checks++;
            if (bus.lcd_rw !== 1'b0) begin
                errors++;
                $display("FAIL %s lcd_rw cyc%0d: got %b want 0", tag, c, bus.lcd_rw);
            end
            if (c == 8) bus.req = req_after;
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.ack !== 2'b00) begin
            errors++;
            $display("FAIL %s idle_gap: got busy=%b ack=%b want busy=0 ack=00", tag, bus.busy, bus.ack);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.lcd_en, bus.lcd_rw, bus.lcd_rs, bus.busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got en,rw,rs,busy=%b want 0000",
                     {bus.lcd_en, bus.lcd_rw, bus.lcd_rs, bus.busy});
        end
        checks++;
        if (bus.lcd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h want 00", bus.lcd_data);
        end
        checks++;
        if (bus.ack !== 2'b00) begin
            errors++;
            $display("FAIL reset_ack: got %b want 00", bus.ack);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        bus.req_data0 = 8'h41;
        bus.req_data1 = 8'h42;
        bus.req_rs    = 2'b11;
        bus.req       = 2'b11;
        check_txn(8'h41, 1'b1, 0, 2'b11, "b2b_1");
`ifdef LCD_ROUND_ROBIN_EN
        check_txn(8'h42, 1'b1, 1, 2'b11, "b2b_2");
`else
        check_txn(8'h41, 1'b1, 0, 2'b11, "b2b_2");
`endif
        // Requester 0 drops after its ack; requester 1 must then be served.
        check_txn(8'h41, 1'b1, 0, 2'b10, "b2b_3");
        check_txn(8'h42, 1'b1, 1, 2'b00, "b2b_4");
    endtask

    task automatic test_single();
        bus.req_data0 = 8'h38;
        bus.req_data1 = 8'hC3;
        bus.req_rs    = 2'b10;
        bus.req       = 2'b01;
        check_txn(8'h38, 1'b0, 0, 2'b00, "single");
    endtask

    task automatic test_early_drop();
        logic [1:0] exp_ack;
        bus.req_data0 = 8'h5A;
        bus.req_data1 = 8'h99;
        bus.req_rs    = 2'b01;
        bus.req       = 2'b01;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            exp_ack = (c == 8) ? 2'b01 : 2'b00;
            checks++;
            if (bus.ack !== exp_ack) begin
                errors++;
                $display("FAIL early_drop ack cyc%0d: got %b want %b", c, bus.ack, exp_ack);
            end
            checks++;
            if (bus.lcd_data !== 8'h5A || bus.lcd_rs !== 1'b1) begin
                errors++;
                $display("FAIL early_drop payload cyc%0d: got %h/%b want 5a/1", c, bus.lcd_data, bus.lcd_rs);
            end
            if (c == 1) bus.req = 2'b11;
            if (c == 2) bus.req = 2'b01;
            if (c == 8) bus.req = 2'b00;
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0 || bus.ack !== 2'b00) begin
                errors++;
                $display("FAIL early_drop after cyc%0d: got busy=%b ack=%b want 0/00", c, bus.busy, bus.ack);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic ack_seen;
        logic busy_seen;
        bus.req_data0 = 8'h55;
        bus.req_rs    = 2'b00;
        bus.req       = 2'b01;
        @(negedge clk);   // SETUP
        @(negedge clk);   // PULSE 1
        checks++;
        if (bus.lcd_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset pulse: got en=%b want 1", bus.lcd_en);
        end
        @(negedge clk);   // PULSE 2
        rst_n   = 1'b0;
        bus.req = 2'b00;
        @(negedge clk);
        checks++;
        if ({bus.lcd_en, bus.busy, bus.lcd_rs} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset ctrl: got en,busy,rs=%b want 000", {bus.lcd_en, bus.busy, bus.lcd_rs});
        end
        checks++;
        if (bus.lcd_data !== 8'h00 || bus.ack !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset data/ack: got %h/%b want 00/00", bus.lcd_data, bus.ack);
        end
        rst_n = 1'b1;
        ack_seen  = 1'b0;
        busy_seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.ack !== 2'b00) ack_seen = 1'b1;
            if (bus.busy !== 1'b0) busy_seen = 1'b1;
        end
        checks++;
        if (ack_seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset no_ack: got ack_seen=%b want 0", ack_seen);
        end
        checks++;
        if (busy_seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset no_busy: got busy_seen=%b want 0", busy_seen);
        end
    endtask

    // After reset the tie must go to requester 0 again.
    task automatic test_reset_ptr();
        bus.req_data0 = 8'h41;
        bus.req_data1 = 8'h42;
        bus.req_rs    = 2'b11;
        bus.req       = 2'b11;
        check_txn(8'h41, 1'b1, 0, 2'b00, "reset_ptr");
    endtask

    initial begin
        clk           = 1'b0;
        rst_n         = 1'b0;
        checks        = 0;
        errors        = 0;
        bus.req       = 2'b00;
        bus.req_rs    = 2'b00;
        bus.req_data0 = 8'h00;
        bus.req_data1 = 8'h00;

        test_reset();
        test_back_to_back();
        test_single();
        test_early_drop();
        test_mid_reset();
        test_reset_ptr();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_bus_arbiter.md
LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 Parameter EN_HIGH_CYC, default 50000, meaning: clk cycles lcd_en is held high per write; legal range 1 to 65535.
REQ-002 Parameter EN_LOW_CYC, default 50000, meaning: clk cycles lcd_en is held low after each pulse; legal range 1 to 65535.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  2  per-requester write request; bit i belongs to requester i.
REQ-006 req_rs  input  2  per-requester register select: 0 = command, 1 = character.
REQ-007 req_data0  input  8  requester 0 byte.
REQ-008 req_data1  input  8  requester 1 byte.
REQ-009 ack  output  2  one-cycle pulse to the granted requester when its write completes.
REQ-010 busy  output  1  high from grant until the ack cycle, inclusive.
REQ-011 lcd_en, lcd_rw, lcd_rs  output  1 each  LCD strobe, read/write (always 0), register select.
REQ-012 lcd_data  output  8  LCD data bus.

Function
REQ-013 The FSM SHALL have states IDLE, SETUP, PULSE and HOLD.
REQ-014 In IDLE with any req bit high, the next edge SHALL grant one requester, register its rs/data onto lcd_rs/lcd_data and enter SETUP.
REQ-015 SETUP SHALL last exactly 1 cycle with lcd_en=0, then enter PULSE.
REQ-016 PULSE SHALL hold lcd_en=1 for exactly EN_HIGH_CYC cycles, then enter HOLD.
REQ-017 HOLD SHALL hold lcd_en=0 for exactly EN_LOW_CYC cycles; in its last cycle ack[granted] SHALL be 1 and the next state SHALL be IDLE.
REQ-018 Total transaction length SHALL be 1+EN_HIGH_CYC+EN_LOW_CYC cycles from the first SETUP cycle to the ack cycle inclusive.
REQ-019 lcd_rs and lcd_data SHALL stay constant from SETUP through HOLD; request inputs SHALL be ignored after grant.
REQ-020 A requester SHALL keep req high until its ack; a req dropped before grant SHALL be ignored, with no ack.
REQ-021 A requester whose req stays high after its ack SHALL be arbitrated normally in the following IDLE cycle; a minimum of 1 IDLE cycle SHALL separate transactions.
REQ-022 The single timing counter SHALL be 16 bits, reset to 0 on every state change, and SHALL never wrap within a state.
REQ-023 ack SHALL never have both bits set, and SHALL never pulse outside HOLD.

Reset
REQ-024 While rst_n=0 at a clock edge, the next state SHALL be IDLE with: lcd_en=0, lcd_rw=0, lcd_rs=0, lcd_data=8'h00, ack=2'b00, busy=0, counter=0, round-robin pointer favouring requester 0.
REQ-025 Reset asserted mid-transaction SHALL abort the transaction with no ack.

Configuration
REQ-026 With LCD_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted alternately, with priority going to the requester not granted last.
REQ-027 Without LCD_ROUND_ROBIN_EN, requester 0 SHALL always win simultaneous requests (fixed priority), and the pointer logic SHALL be absent.

Structure
REQ-028 Package lcd_pkg SHALL hold:
- the FSM state typedef;
- constants RS_CMD=1'b0 and RS_CHAR=1'b1;
- the default timing constant 50000.
REQ-029 Grant selection SHALL live in one sub-module, lcd_rr_arbiter (2-way, fixed or round-robin by macro).

Verification (EN_HIGH_CYC=4, EN_LOW_CYC=3)
REQ-030 Single request: req=01, rs=0, data0=8'h38 -> lcd_data=8'h38 and lcd_rs=0 for 8 cycles; lcd_en high for 4 cycles; ack=01 on the 8th cycle; busy=1 for those 8 cycles.
REQ-031 Simultaneous requests, round-robin: req=11 held, data0=8'h41, data1=8'h42, rs=11 -> lcd_data sequence 41, 42, 41; acks alternate 01, 10, 01.
REQ-032 Simultaneous requests, fixed priority (macro undefined): req=11 held -> only 8'h41 is written and only ack=01 pulses until req[0] drops.
REQ-033 Reset mid-transaction: rst_n=0 at the 2nd PULSE cycle -> next cycle lcd_en=0, busy=0, lcd_data=00, and no ack ever for that write.
REQ-034 Early drop: req[1] pulsed for 1 cycle while requester 0 is busy -> no grant to and no ack for requester 1.
